// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: receive side of the seven-segment link. It deserialises NDIGITS
// MSB-first segment patterns, decodes them to BCD and a binary value, and flags frames
// the encoder could not have produced.
`default_nettype none

module seg_frame_decoder #(
  parameter int NDIGITS = 3,
  parameter int VW      = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sbit,
  input  logic                   sbit_vld,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     blank_mask,
  output logic [VW-1:0]          value,
  output logic                   err
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [2:0]           bit_cnt_q;
  logic [IW-1:0]        dig_idx_q;
  logic [6:0]           shreg_q;
  logic [4*NDIGITS-1:0] dig_sh_q, dig_sh_d;
  logic [NDIGITS-1:0]   blank_sh_q, blank_sh_d;
  logic                 err_sh_q, err_sh_d;
  logic                 nonblank_q, nonblank_d;
  logic [VW-1:0]        acc_q, acc_d;

  logic [7:0] pat;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic       dec_err;
  logic       accept;
  logic       byte_end;
  logic       last_bit;

  assign accept   = (state_q == S_SHIFT) && sbit_vld;
  assign byte_end = accept && (bit_cnt_q == 3'd7);
  assign last_bit = byte_end && (dig_idx_q == '0);

  // The eighth bit is still on the wire, so the pattern is decoded before it lands in shreg.
  always_comb begin
    pat       = {shreg_q, sbit};
    dec_digit = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    if (pat[7]) begin
      dec_err = 1'b1;
    end else begin
      case (pat[6:0])
        7'h3F: dec_digit = 4'd0;
        7'h06: dec_digit = 4'd1;
        7'h5B: dec_digit = 4'd2;
        7'h4F: dec_digit = 4'd3;
        7'h66: dec_digit = 4'd4;
        7'h6D: dec_digit = 4'd5;
        7'h7D: dec_digit = 4'd6;
        7'h07: dec_digit = 4'd7;
        7'h7F: dec_digit = 4'd8;
        7'h67: dec_digit = 4'd9;
        7'h00: begin dec_digit = 4'd0; dec_blank = 1'b1; end
        7'h77: begin dec_digit = 4'hA; dec_err = 1'b1; end
        7'h7C: begin dec_digit = 4'hB; dec_err = 1'b1; end
        7'h39: begin dec_digit = 4'hC; dec_err = 1'b1; end
        7'h5E: begin dec_digit = 4'hD; dec_err = 1'b1; end
        7'h79: begin dec_digit = 4'hE; dec_err = 1'b1; end
        7'h71: begin dec_digit = 4'hF; dec_err = 1'b1; end
        default: dec_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    dig_sh_d   = dig_sh_q;
    blank_sh_d = blank_sh_q;
    err_sh_d   = err_sh_q;
    nonblank_d = nonblank_q;
    acc_d      = acc_q;
    if (byte_end) begin
      dig_sh_d[int'(dig_idx_q)*4 +: 4] = dec_digit;
      blank_sh_d[dig_idx_q]            = dec_blank;
      // Leading blanks only: a blank LSD or a blank after any lit digit is impossible.
      err_sh_d   = err_sh_q | dec_err |
                   (dec_blank & ((dig_idx_q == '0) | nonblank_q));
      nonblank_d = nonblank_q | ~dec_blank;
      acc_d      = VW'(acc_q * VW'(10)) + {{(VW-4){1'b0}}, dec_digit};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      dig_idx_q  <= '0;
      shreg_q    <= '0;
      dig_sh_q   <= '0;
      blank_sh_q <= '0;
      err_sh_q   <= 1'b0;
      nonblank_q <= 1'b0;
      acc_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      digits     <= '0;
      blank_mask <= '0;
      value      <= '0;
      err        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q    <= S_SHIFT;
            busy       <= 1'b1;
            bit_cnt_q  <= '0;
            dig_idx_q  <= IW'(NDIGITS - 1);
            shreg_q    <= '0;
            dig_sh_q   <= '0;
            blank_sh_q <= '0;
            err_sh_q   <= 1'b0;
            nonblank_q <= 1'b0;
            acc_q      <= '0;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            shreg_q    <= {shreg_q[5:0], sbit};
            bit_cnt_q  <= byte_end ? 3'd0 : bit_cnt_q + 3'd1;
            dig_sh_q   <= dig_sh_d;
            blank_sh_q <= blank_sh_d;
            err_sh_q   <= err_sh_d;
            nonblank_q <= nonblank_d;
            acc_q      <= acc_d;
            if (last_bit) begin
              state_q    <= S_DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              digits     <= dig_sh_d;
              blank_mask <= blank_sh_d;
              err        <= err_sh_d;
              value      <= err_sh_d ? '0 : acc_d;
            end else if (byte_end) begin
              dig_idx_q <= dig_idx_q - IW'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_frame_decoder.sv
// tb_seg_frame_decoder: directed frames with a scoreboard of expected results that is
// popped whenever the decoder pulses done.
`default_nettype none

module tb_seg_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sbit;
  logic        sbit_vld;
  logic        busy;
  logic        done;
  logic [11:0] digits;
  logic [2:0]  blank_mask;
  logic [9:0]  value;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] dg;
    logic [2:0]  bm;
    logic [9:0]  val;
    logic        er;
    bit          full;
  } exp_t;

  exp_t sb[$];

  seg_frame_decoder #(.NDIGITS(3), .VW(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .sbit       (sbit),
    .sbit_vld   (sbit_vld),
    .busy       (busy),
    .done       (done),
    .digits     (digits),
    .blank_mask (blank_mask),
    .value      (value),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] dg, input logic [2:0] bm,
                              input logic [9:0] val, input logic er, input bit full);
    exp_t e;
    e.dg = dg; e.bm = bm; e.val = val; e.er = er; e.full = full;
    return e;
  endfunction

  // Scoreboard consumer: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err", {31'd0, err}, {31'd0, e.er});
        chk("value", {22'd0, value}, {22'd0, e.val});
        if (e.full) begin
          chk("digits", {20'd0, digits}, {20'd0, e.dg});
          chk("blank_mask", {29'd0, blank_mask}, {29'd0, e.bm});
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] p2, input logic [7:0] p1, input logic [7:0] p0,
                            input bit gaps, input bit midstart, input exp_t e);
    logic [7:0] pats [3];
    pats[0] = p2; pats[1] = p1; pats[2] = p0;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int d = 0; d < 3; d++) begin
      for (int b = 7; b >= 0; b--) begin
        if (gaps) begin
          sbit_vld = 1'b0;
          sbit     = 1'b1;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        start    = (midstart && d == 1 && b == 4);
        sbit     = pats[d][b];
        sbit_vld = 1'b1;
        @(negedge clk);
      end
    end
    start    = 1'b0;
    sbit_vld = 1'b0;
    sbit     = 1'b0;
    chk("done_after_last_bit", {31'd0, done}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    sbit     = 1'b0;
    sbit_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_digits", {20'd0, digits}, 32'd0);
    chk("rst_blank", {29'd0, blank_mask}, 32'd0);
    chk("rst_value", {22'd0, value}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Serial activity while idle must not start or disturb anything.
    sbit_vld = 1'b1;
    sbit     = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_vld_busy", {31'd0, busy}, 32'd0);
    chk("idle_vld_done", {31'd0, done}, 32'd0);
    sbit_vld = 1'b0;
    sbit     = 1'b0;

    send_frame(8'h00, 8'h00, 8'h3F, 1'b0, 1'b0, mk(12'h000, 3'b110, 10'd0, 1'b0, 1'b1));
    send_frame(8'h00, 8'h06, 8'h5B, 1'b0, 1'b0, mk(12'h012, 3'b100, 10'd12, 1'b0, 1'b1));
    send_frame(8'h67, 8'h67, 8'h67, 1'b1, 1'b0, mk(12'h999, 3'b000, 10'd999, 1'b0, 1'b1));
    send_frame(8'h06, 8'h77, 8'h06, 1'b0, 1'b0, mk(12'h1A1, 3'b000, 10'd0, 1'b1, 1'b1));
    send_frame(8'h06, 8'h00, 8'h06, 1'b0, 1'b0, mk(12'h101, 3'b010, 10'd0, 1'b1, 1'b1));
    send_frame(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, mk(12'h000, 3'b111, 10'd0, 1'b1, 1'b1));
    send_frame(8'h06, 8'h06, 8'h86, 1'b0, 1'b0, mk(12'h000, 3'b000, 10'd0, 1'b1, 1'b0));

    // Outputs hold between frames.
    repeat (3) @(negedge clk);
    chk("hold_err", {31'd0, err}, 32'd1);

    // Abandon a frame after 10 bits.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sbit     = i[0];
      sbit_vld = 1'b1;
      @(negedge clk);
    end
    sbit_vld = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_digits", {20'd0, digits}, 32'd0);
    chk("midrst_blank", {29'd0, blank_mask}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send_frame(8'h4F, 8'h3F, 8'h3F, 1'b0, 1'b1, mk(12'h300, 3'b000, 10'd300, 1'b0, 1'b1));

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
